// File: rtl/gpr_access_ctrl.sv
// Sequencer and arbiter for the single-port 8x16 GPR: serialises Ra/Rb reads, exec wait
// and Rd writeback for the datapath, and interleaves a low-rate debug port fairly.
module gpr_access_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 3,
  parameter int EXEC_TIMEOUT = 15
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  OpReq,
  output logic                  OpAck,
  input  logic [ADDR_WIDTH-1:0] RaAddr,
  input  logic [ADDR_WIDTH-1:0] RbAddr,
  input  logic [ADDR_WIDTH-1:0] RdAddr,
  input  logic                  WbEn,
  output logic [DATA_WIDTH-1:0] OpA,
  output logic [DATA_WIDTH-1:0] OpB,
  output logic                  OpsValid,
  input  logic [DATA_WIDTH-1:0] Result,
  input  logic                  ResultValid,
  output logic                  Done,
  output logic                  OpErr,
  input  logic                  DbgReq,
  input  logic                  DbgWrite,
  input  logic [ADDR_WIDTH-1:0] DbgAddr,
  input  logic [DATA_WIDTH-1:0] DbgWData,
  output logic [DATA_WIDTH-1:0] DbgRData,
  output logic                  DbgAck,
  output logic [ADDR_WIDTH-1:0] GprAddress,
  output logic                  GprRead,
  output logic                  GprWrite,
  output logic [DATA_WIDTH-1:0] GprWData,
  input  logic [DATA_WIDTH-1:0] GprRData
);

  localparam int CNT_W = $clog2(EXEC_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(EXEC_TIMEOUT);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB, DBG} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   ra_reg, rb_reg, rd_reg, dbg_addr_reg;
  logic                    wb_en_reg, abort_reg, last_dbg_reg;
  logic                    dbg_write_reg, dbg_ack_reg;
  logic [DATA_WIDTH-1:0]   opa_reg, opb_reg, result_reg;
  logic [DATA_WIDTH-1:0]   dbg_wdata_reg, dbg_rdata_reg;
  logic [CNT_W-1:0]        cnt_reg, cnt_inc;
  logic                    dbg_pend, grant_op, grant_dbg, timeout_hit;

  // The debug requester still holds DbgReq during its ack cycle; that is not a new request.
  assign dbg_pend = DbgReq && !dbg_ack_reg;
  assign cnt_inc  = cnt_reg + CNT_W'(1);

  assign OpA      = opa_reg;
  assign OpB      = opb_reg;
  assign DbgRData = dbg_rdata_reg;
  assign DbgAck   = dbg_ack_reg;

  always_comb begin
    state_next  = state_reg;
    OpAck       = 1'b0;
    OpsValid    = 1'b0;
    Done        = 1'b0;
    OpErr       = 1'b0;
    GprRead     = 1'b0;
    GprWrite    = 1'b0;
    GprAddress  = '0;
    GprWData    = '0;
    grant_op    = 1'b0;
    grant_dbg   = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        // Under contention the side that did not win last time gets the port.
        if (OpReq && (!dbg_pend || last_dbg_reg)) begin
          grant_op   = 1'b1;
          OpAck      = 1'b1;
          state_next = RD_A;
        end else if (dbg_pend) begin
          grant_dbg  = 1'b1;
          state_next = DBG;
        end
      end
      RD_A: begin
        GprRead    = 1'b1;
        GprAddress = ra_reg;
        state_next = RD_B;
      end
      RD_B: begin
        GprRead    = 1'b1;
        GprAddress = rb_reg;
        state_next = EXEC;
      end
      EXEC: begin
        OpsValid = 1'b1;
        if (ResultValid) begin
          state_next = WB;
        end else if ((EXEC_TIMEOUT != 0) && (cnt_inc == TIMEOUT_VAL)) begin
          timeout_hit = 1'b1;
          state_next  = WB;
        end
      end
      WB: begin
        Done  = 1'b1;
        OpErr = abort_reg;
        if (wb_en_reg && (rd_reg != '0) && !abort_reg) begin
          GprWrite   = 1'b1;
          GprAddress = rd_reg;
          GprWData   = result_reg;
        end
        state_next = IDLE;
      end
      DBG: begin
        GprAddress = dbg_addr_reg;
        if (dbg_write_reg) begin
          GprWrite = 1'b1;
          GprWData = dbg_wdata_reg;
        end else begin
          GprRead = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg     <= IDLE;
      ra_reg        <= '0;
      rb_reg        <= '0;
      rd_reg        <= '0;
      wb_en_reg     <= 1'b0;
      abort_reg     <= 1'b0;
      last_dbg_reg  <= 1'b1;
      dbg_addr_reg  <= '0;
      dbg_write_reg <= 1'b0;
      dbg_wdata_reg <= '0;
      dbg_rdata_reg <= '0;
      dbg_ack_reg   <= 1'b0;
      opa_reg       <= '0;
      opb_reg       <= '0;
      result_reg    <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg   <= state_next;
      dbg_ack_reg <= (state_reg == DBG);
      cnt_reg     <= (state_reg == EXEC) ? cnt_inc : '0;
      if (grant_op) begin
        ra_reg    <= RaAddr;
        rb_reg    <= RbAddr;
        rd_reg    <= RdAddr;
        wb_en_reg <= WbEn;
        abort_reg <= 1'b0;
      end
      if (grant_dbg) begin
        dbg_addr_reg  <= DbgAddr;
        dbg_write_reg <= DbgWrite;
        dbg_wdata_reg <= DbgWData;
      end
      // Register 0 captures as zero regardless of what the bus carries.
      if (state_reg == RD_A) opa_reg <= (ra_reg == '0) ? '0 : GprRData;
      if (state_reg == RD_B) opb_reg <= (rb_reg == '0) ? '0 : GprRData;
      if (state_reg == EXEC) begin
        if (ResultValid) result_reg <= Result;
        else if (timeout_hit) abort_reg <= 1'b1;
      end
      if (state_reg == WB) last_dbg_reg <= 1'b0;
      if (state_reg == DBG) begin
        last_dbg_reg <= 1'b1;
        if (!dbg_write_reg) dbg_rdata_reg <= (dbg_addr_reg == '0) ? '0 : GprRData;
      end
    end
  end

endmodule

// File: tb/tb_gpr_access_ctrl.sv
// Bench for gpr_access_ctrl: behavioural GPR on the port, reference register model,
// and queues of expected op/debug results popped as the controller completes them.
module tb_gpr_access_ctrl;

  logic        Clock, Reset;
  logic        OpReq, OpAck, WbEn, OpsValid, ResultValid, Done, OpErr;
  logic [2:0]  RaAddr, RbAddr, RdAddr, DbgAddr, GprAddress;
  logic [15:0] OpA, OpB, Result, DbgWData, DbgRData, GprWData, GprRData;
  logic        DbgReq, DbgWrite, DbgAck, GprRead, GprWrite;

  typedef struct packed {
    logic [15:0] opa;
    logic [15:0] opb;
    logic        wr;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        err;
  } op_exp_t;

  typedef struct {
    op_exp_t d;
    int      done_cnt;
    int      ops_lat;
    int      done_lat;
    int      exec_cycles;
    int      stray_wr;
    bit      timeout;
  } op_obs_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          both_cnt = 0;
  logic [15:0] gpr_mem [8];
  logic [15:0] ref_regs [8];
  op_exp_t     op_q [$];
  logic [15:0] rd_q [$];

  gpr_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .EXEC_TIMEOUT(4)) dut (
    .Clock(Clock), .Reset(Reset), .OpReq(OpReq), .OpAck(OpAck),
    .RaAddr(RaAddr), .RbAddr(RbAddr), .RdAddr(RdAddr), .WbEn(WbEn),
    .OpA(OpA), .OpB(OpB), .OpsValid(OpsValid), .Result(Result),
    .ResultValid(ResultValid), .Done(Done), .OpErr(OpErr),
    .DbgReq(DbgReq), .DbgWrite(DbgWrite), .DbgAddr(DbgAddr), .DbgWData(DbgWData),
    .DbgRData(DbgRData), .DbgAck(DbgAck), .GprAddress(GprAddress),
    .GprRead(GprRead), .GprWrite(GprWrite), .GprWData(GprWData), .GprRData(GprRData)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Behavioural GPR: R0 reads zero and ignores writes; bus carries junk when not read.
  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) gpr_mem[i] <= '0;
    end else if (GprWrite && GprAddress != 3'd0) begin
      gpr_mem[GprAddress] <= GprWData;
    end
  end
  assign GprRData = GprRead ? ((GprAddress == 3'd0) ? 16'h0000 : gpr_mem[GprAddress]) : 16'hDEAD;

  always @(negedge Clock) if (GprRead && GprWrite) both_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [73:0] out_vec();
    return {OpAck, OpsValid, Done, OpErr, DbgAck, GprRead, GprWrite, GprAddress,
            GprWData, OpA, OpB, DbgRData};
  endfunction

  task automatic predict_op(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                            input logic wb, input logic [15:0] res, input logic abort);
    op_exp_t e;
    e.opa   = ref_regs[ra];
    e.opb   = ref_regs[rb];
    e.wr    = wb && (rd != 3'd0) && !abort;
    e.waddr = e.wr ? rd : 3'd0;
    e.wdata = e.wr ? res : 16'h0000;
    e.err   = abort;
    op_q.push_back(e);
    if (e.wr) ref_regs[rd] = res;
  endtask

  task automatic predict_dbg(input logic wr, input logic [2:0] addr, input logic [15:0] data);
    if (wr) begin
      if (addr != 3'd0) ref_regs[addr] = data;
    end else begin
      rd_q.push_back(ref_regs[addr]);
    end
  endtask

  task automatic dbg_access(input logic wr, input logic [2:0] addr, input logic [15:0] wdata,
                            output logic [15:0] rdata, output bit ok);
    ok = 1'b0;
    rdata = '0;
    @(posedge Clock); #1;
    DbgReq = 1'b1; DbgWrite = wr; DbgAddr = addr; DbgWData = wdata;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge Clock);
      if (DbgAck) begin
        ok = 1'b1;
        rdata = DbgRData;
      end
    end
    @(posedge Clock); #1;
    DbgReq = 1'b0;
    $display("[TB] dbg %s R%0d wdata=%h rdata=%h acked=%0d", wr ? "wr" : "rd", addr, wdata, rdata, ok);
  endtask

  // rv_delay: EXEC cycle index in which ResultValid is driven; negative = never.
  task automatic run_op(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                        input logic wb, input logic [15:0] res, input int rv_delay,
                        output op_obs_t o);
    bit acked, finished;
    int exec_n;
    o.d = '0; o.done_cnt = 0; o.ops_lat = 0; o.done_lat = 0;
    o.exec_cycles = 0; o.stray_wr = 0; o.timeout = 1'b0;
    acked = 1'b0; finished = 1'b0; exec_n = 0;
    @(posedge Clock); #1;
    OpReq = 1'b1; RaAddr = ra; RbAddr = rb; RdAddr = rd; WbEn = wb;
    for (int i = 0; i < 40 && !acked; i++) begin
      @(negedge Clock);
      if (OpAck) acked = 1'b1;
    end
    @(posedge Clock); #1;
    OpReq = 1'b0;
    if (acked) begin
      for (int k = 1; k <= 30 && !finished; k++) begin
        @(negedge Clock);
        ResultValid = 1'b0;
        if (OpsValid) begin
          if (exec_n == 0) begin
            o.ops_lat = k; o.d.opa = OpA; o.d.opb = OpB;
          end
          if (exec_n == rv_delay) begin
            ResultValid = 1'b1; Result = res;
          end
          exec_n++;
        end
        if (Done) begin
          o.done_cnt++; o.done_lat = k; o.d.err = OpErr; o.d.wr = GprWrite;
          if (GprWrite) begin
            o.d.waddr = GprAddress; o.d.wdata = GprWData;
          end
        end else begin
          if (GprWrite) o.stray_wr++;
          if (o.done_cnt > 0) finished = 1'b1;
        end
      end
    end
    ResultValid = 1'b0;
    o.exec_cycles = exec_n;
    o.timeout = !finished;
    $display("[TB] op Ra=%0d Rb=%0d Rd=%0d WbEn=%0d OpA=%h OpB=%h wr=%0d@%0d=%h err=%0d exec=%0d",
             ra, rb, rd, wb, o.d.opa, o.d.opb, o.d.wr, o.d.waddr, o.d.wdata, o.d.err, exec_n);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clock);
    tests_run++;
    if (out_vec() !== 74'd0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h required 0", out_vec());
    end
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    @(negedge Clock);
    tests_run++;
    if (out_vec() !== 74'd0) begin
      tests_failed++; $display("FAIL reset_idle: got %h required 0", out_vec());
    end
  endtask

  task automatic test_basic_op();
    logic [15:0] rd, exp_rd;
    bit ok;
    op_obs_t o;
    op_exp_t e;
    predict_dbg(1'b1, 3'd1, 16'h1234);
    dbg_access(1'b1, 3'd1, 16'h1234, rd, ok);
    predict_dbg(1'b1, 3'd2, 16'h0F0F);
    dbg_access(1'b1, 3'd2, 16'h0F0F, rd, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL basic_dbg_write_ack: got %0d required 1", ok);
    end
    predict_op(3'd1, 3'd2, 3'd3, 1'b1, 16'h1F43, 1'b0);
    run_op(3'd1, 3'd2, 3'd3, 1'b1, 16'h1F43, 0, o);
    e = op_q.pop_front();
    tests_run++;
    if ({o.timeout, o.d} !== {1'b0, e}) begin
      tests_failed++; $display("FAIL basic_op: got %h required %h", {o.timeout, o.d}, {1'b0, e});
    end
    tests_run++;
    if (o.ops_lat !== 3 || o.done_lat !== 4 || o.done_cnt !== 1 || o.stray_wr !== 0) begin
      tests_failed++;
      $display("FAIL basic_latency: got ops=%0d done=%0d pulses=%0d stray=%0d required 3 4 1 0",
               o.ops_lat, o.done_lat, o.done_cnt, o.stray_wr);
    end
    predict_dbg(1'b0, 3'd3, 16'h0);
    dbg_access(1'b0, 3'd3, 16'h0, rd, ok);
    exp_rd = rd_q.pop_front();
    tests_run++;
    if (!ok || rd !== exp_rd) begin
      tests_failed++; $display("FAIL basic_dbg_read_r3: got %h required %h", rd, exp_rd);
    end
  endtask

  task automatic test_zero_reg();
    logic [15:0] rd, exp_rd;
    bit ok;
    op_obs_t o;
    op_exp_t e;
    predict_op(3'd0, 3'd1, 3'd0, 1'b1, 16'hBEEF, 1'b0);
    run_op(3'd0, 3'd1, 3'd0, 1'b1, 16'hBEEF, 1, o);
    e = op_q.pop_front();
    tests_run++;
    if ({o.timeout, o.d} !== {1'b0, e} || o.done_cnt !== 1 || o.stray_wr !== 0) begin
      tests_failed++;
      $display("FAIL zero_reg_op: got %h pulses=%0d required %h pulses=1", {o.timeout, o.d}, o.done_cnt, {1'b0, e});
    end
    predict_dbg(1'b1, 3'd0, 16'h5555);
    dbg_access(1'b1, 3'd0, 16'h5555, rd, ok);
    predict_dbg(1'b0, 3'd0, 16'h0);
    dbg_access(1'b0, 3'd0, 16'h0, rd, ok);
    exp_rd = rd_q.pop_front();
    tests_run++;
    if (!ok || rd !== exp_rd) begin
      tests_failed++; $display("FAIL zero_reg_dbg_read: got %h required %h", rd, exp_rd);
    end
  endtask

  task automatic test_arbitration();
    logic [15:0] rd, exp_rd;
    bit ok, drop_op, drop_dbg;
    int n_op, n_dbg, exp_g;
    int grant_q [$];
    // A debug grant first so the next contention is won by the op side.
    predict_dbg(1'b0, 3'd2, 16'h0);
    dbg_access(1'b0, 3'd2, 16'h0, rd, ok);
    exp_rd = rd_q.pop_front();
    tests_run++;
    if (!ok || rd !== exp_rd) begin
      tests_failed++; $display("FAIL arb_pre_read: got %h required %h", rd, exp_rd);
    end
    for (int r = 0; r < 3; r++) begin
      grant_q.push_back(0);
      grant_q.push_back(1);
    end
    n_op = 0; n_dbg = 0;
    @(posedge Clock); #1;
    OpReq = 1'b1; RaAddr = 3'd1; RbAddr = 3'd2; RdAddr = 3'd7; WbEn = 1'b0;
    DbgReq = 1'b1; DbgWrite = 1'b0; DbgAddr = 3'd1;
    ResultValid = 1'b1; Result = 16'h7777;
    for (int c = 0; c < 100 && (n_op < 3 || n_dbg < 3); c++) begin
      @(negedge Clock);
      drop_op = 1'b0; drop_dbg = 1'b0;
      if (DbgAck) begin
        n_dbg++;
        exp_g = (grant_q.size() > 0) ? grant_q.pop_front() : -1;
        tests_run++;
        if (exp_g !== 1) begin
          tests_failed++; $display("FAIL arb_order: got dbg grant required %0d", exp_g);
        end
        $display("[TB] arb grant dbg #%0d", n_dbg);
        drop_dbg = (n_dbg == 3);
      end
      if (OpAck) begin
        n_op++;
        exp_g = (grant_q.size() > 0) ? grant_q.pop_front() : -1;
        tests_run++;
        if (exp_g !== 0) begin
          tests_failed++; $display("FAIL arb_order: got op grant required %0d", exp_g);
        end
        $display("[TB] arb grant op #%0d", n_op);
        drop_op = (n_op == 3);
      end
      if (drop_op || drop_dbg) begin
        @(posedge Clock); #1;
        if (drop_op) OpReq = 1'b0;
        if (drop_dbg) DbgReq = 1'b0;
      end
    end
    OpReq = 1'b0; DbgReq = 1'b0; ResultValid = 1'b0;
    tests_run++;
    if (n_op !== 3 || n_dbg !== 3) begin
      tests_failed++; $display("FAIL arb_counts: got op=%0d dbg=%0d required 3 3", n_op, n_dbg);
    end
    repeat (6) @(negedge Clock);
  endtask

  task automatic test_timeout();
    op_obs_t o;
    op_exp_t e;
    predict_op(3'd2, 3'd1, 3'd6, 1'b1, 16'hAAAA, 1'b1);
    run_op(3'd2, 3'd1, 3'd6, 1'b1, 16'hAAAA, -1, o);
    e = op_q.pop_front();
    tests_run++;
    if ({o.timeout, o.d} !== {1'b0, e}) begin
      tests_failed++; $display("FAIL timeout_op: got %h required %h", {o.timeout, o.d}, {1'b0, e});
    end
    tests_run++;
    if (o.exec_cycles !== 4 || o.done_cnt !== 1 || o.stray_wr !== 0) begin
      tests_failed++;
      $display("FAIL timeout_cycles: got exec=%0d pulses=%0d stray=%0d required 4 1 0",
               o.exec_cycles, o.done_cnt, o.stray_wr);
    end
    // Result in the last EXEC cycle before the limit must still win.
    predict_op(3'd1, 3'd2, 3'd6, 1'b1, 16'h4321, 1'b0);
    run_op(3'd1, 3'd2, 3'd6, 1'b1, 16'h4321, 3, o);
    e = op_q.pop_front();
    tests_run++;
    if ({o.timeout, o.d} !== {1'b0, e} || o.exec_cycles !== 4) begin
      tests_failed++;
      $display("FAIL timeout_edge_result: got %h exec=%0d required %h exec=4", {o.timeout, o.d}, o.exec_cycles, {1'b0, e});
    end
  endtask

  task automatic test_reset_mid_op();
    bit acked;
    op_obs_t o;
    op_exp_t e;
    acked = 1'b0;
    @(posedge Clock); #1;
    OpReq = 1'b1; RaAddr = 3'd1; RbAddr = 3'd2; RdAddr = 3'd4; WbEn = 1'b1;
    for (int i = 0; i < 40 && !acked; i++) begin
      @(negedge Clock);
      if (OpAck) acked = 1'b1;
    end
    @(posedge Clock); #1;
    OpReq = 1'b0;
    repeat (2) @(negedge Clock);
    tests_run++;
    if ({acked, GprRead, GprAddress} !== {1'b1, 1'b1, 3'd2}) begin
      tests_failed++;
      $display("FAIL rst_mid_rdb: got ack=%0d rd=%0d addr=%0d required 1 1 2", acked, GprRead, GprAddress);
    end
    #1 Reset = 1'b1;
    #1;
    tests_run++;
    if (out_vec() !== 74'd0) begin
      tests_failed++; $display("FAIL rst_mid_outputs: got %h required 0", out_vec());
    end
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      tests_run++;
      if ({Done, DbgAck, OpsValid, GprWrite} !== 4'b0) begin
        tests_failed++;
        $display("FAIL rst_mid_quiet: got Done=%0d DbgAck=%0d OpsValid=%0d GprWrite=%0d required 0",
                 Done, DbgAck, OpsValid, GprWrite);
      end
    end
    predict_op(3'd0, 3'd0, 3'd5, 1'b1, 16'hABCD, 1'b0);
    run_op(3'd0, 3'd0, 3'd5, 1'b1, 16'hABCD, 0, o);
    e = op_q.pop_front();
    tests_run++;
    if ({o.timeout, o.d} !== {1'b0, e} || o.ops_lat !== 3 || o.done_lat !== 4) begin
      tests_failed++;
      $display("FAIL rst_mid_next_op: got %h ops=%0d done=%0d required %h 3 4",
               {o.timeout, o.d}, o.ops_lat, o.done_lat, {1'b0, e});
    end
  endtask

  task automatic test_random();
    logic [15:0] rd, exp_rd, data;
    logic [2:0]  a, b, d;
    logic        wb;
    bit          ok;
    op_obs_t     o;
    op_exp_t     e;
    int          sel, dly;
    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 2);
      a    = 3'($urandom_range(0, 7));
      b    = 3'($urandom_range(0, 7));
      d    = 3'($urandom_range(0, 7));
      wb   = 1'($urandom_range(0, 1));
      data = 16'($urandom);
      dly  = $urandom_range(0, 3);
      if (sel == 0) begin
        predict_dbg(1'b1, a, data);
        dbg_access(1'b1, a, data, rd, ok);
        tests_run++;
        if (!ok) begin
          tests_failed++; $display("FAIL rand_dbg_write_ack: got %0d required 1", ok);
        end
      end else if (sel == 1) begin
        predict_dbg(1'b0, a, 16'h0);
        dbg_access(1'b0, a, 16'h0, rd, ok);
        exp_rd = rd_q.pop_front();
        tests_run++;
        if (!ok || rd !== exp_rd) begin
          tests_failed++; $display("FAIL rand_dbg_read R%0d: got %h required %h", a, rd, exp_rd);
        end
      end else begin
        predict_op(a, b, d, wb, data, 1'b0);
        run_op(a, b, d, wb, data, dly, o);
        e = op_q.pop_front();
        tests_run++;
        if ({o.timeout, o.d} !== {1'b0, e} || o.stray_wr !== 0) begin
          tests_failed++;
          $display("FAIL rand_op: got %h stray=%0d required %h", {o.timeout, o.d}, o.stray_wr, {1'b0, e});
        end
      end
    end
    tests_run++;
    if (both_cnt !== 0) begin
      tests_failed++; $display("FAIL read_write_overlap: got %0d cycles required 0", both_cnt);
    end
    for (int i = 1; i < 8; i++) begin
      tests_run++;
      if (gpr_mem[i] !== ref_regs[i]) begin
        tests_failed++; $display("FAIL reg_contents R%0d: got %h required %h", i, gpr_mem[i], ref_regs[i]);
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    OpReq = 1'b0; RaAddr = '0; RbAddr = '0; RdAddr = '0; WbEn = 1'b0;
    Result = '0; ResultValid = 1'b0;
    DbgReq = 1'b0; DbgWrite = 1'b0; DbgAddr = '0; DbgWData = '0;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    test_reset();
    test_basic_op();
    test_zero_reg();
    test_arbitration();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gpr_access_ctrl.md
Name: gpr_access_ctrl

Overview:
Sequencing and arbitration controller for the single-port general-purpose register file (8 x 16, register 0 reads as zero, write ignored).
- Serialises a three-operand datapath operation over the one GPR port in this order: read Ra, read Rb, present operands, wait for the result, write back Rd.
- Arbitrates the port fairly between the datapath sequencer and a low-rate debug read/write port.
- Sits between the instruction control unit/ALU and the GPR, and owns the GPR Address/Read/Write/DataIn pins exclusively.

Parameters:
DATA_WIDTH, 16, register/operand width
ADDR_WIDTH, 3, GPR address width (register 0 is the zero register)
EXEC_TIMEOUT, 15, max cycles in EXEC waiting for ResultValid; 0 disables timeout

Ports:
Clock  in  1  single system clock, posedge
Reset  in  1  asynchronous, active-high reset
OpReq  in  1  datapath op request; held until OpAck
OpAck  out  1  op accepted this cycle (combinational, IDLE only)
RaAddr  in  ADDR_WIDTH  operand A register; sampled on accept
RbAddr  in  ADDR_WIDTH  operand B register; sampled on accept
RdAddr  in  ADDR_WIDTH  destination register; sampled on accept
WbEn  in  1  writeback required; sampled on accept
OpA  out  DATA_WIDTH  latched operand A
OpB  out  DATA_WIDTH  latched operand B
OpsValid  out  1  operands valid (high throughout EXEC)
Result  in  DATA_WIDTH  ALU result
ResultValid  in  1  Result valid this cycle
Done  out  1  op complete (high for the one WB cycle)
OpErr  out  1  timeout abort (high in WB of an aborted op)
DbgReq  in  1  debug request; held until DbgAck
DbgWrite  in  1  1 = write, 0 = read
DbgAddr  in  ADDR_WIDTH  debug register address
DbgWData  in  DATA_WIDTH  debug write data
DbgRData  out  DATA_WIDTH  debug read data, held until next debug read
DbgAck  out  1  one-cycle pulse, cycle after DBG
GprAddress  out  ADDR_WIDTH  to GPR Address
GprRead  out  1  to GPR Read
GprWrite  out  1  to GPR Write
GprWData  out  DATA_WIDTH  to GPR DataIn
GprRData  in  DATA_WIDTH  from GPR DataOut (tri-state bus; valid only while GprRead=1)

Behaviour:
- Reset (async, any state): FSM goes to IDLE. All outputs 0. OpA, OpB, DbgRData, result latch and timeout counter cleared. Fairness flag set to op-first. An op or debug access in flight is abandoned with no Done and no DbgAck.
- States: IDLE, RD_A, RD_B, EXEC, WB, DBG.
- IDLE: GprRead=0, GprWrite=0, GprAddress=0. Grant rules:
  - If only OpReq is pending, grant the op.
  - If only DbgReq is pending, grant debug.
  - If both are pending, grant debug if the last grant was an op, otherwise grant the op (alternating).
  - Op grant: OpAck=1, latch Ra/Rb/Rd/WbEn, next state RD_A.
  - Debug grant: latch DbgAddr/DbgWrite/DbgWData, next state DBG.
- RD_A: GprRead=1, GprAddress=Ra. At the clock edge, OpA <= GprRData. Next state RD_B.
- RD_B: same as RD_A for Rb into OpB. Next state EXEC.
- Ra or Rb = 0 still takes its read cycle (fixed latency); the captured value is 0.
- EXEC: OpsValid=1, GPR idle. The counter increments each cycle.
  - On ResultValid, latch Result and go to WB.
  - If EXEC_TIMEOUT != 0 and the counter reaches EXEC_TIMEOUT without ResultValid, set the abort flag and go to WB.
- WB: Done=1.
  - GprWrite=1, GprAddress=Rd, GprWData=result latch only if WbEn=1, Rd != 0 and not aborted.
  - Otherwise the GPR stays idle.
  - OpErr=1 if aborted.
  - Next state IDLE; last-grant flag = op.
- DBG: one cycle.
  - Read: GprRead=1 and DbgRData <= GprRData at the edge.
  - Write: GprWrite=1 and GprWData=DbgWData (address 0 leaves GPR contents unchanged).
  - Next state IDLE; DbgAck=1 in the following cycle; last-grant flag = debug.
- Invariant: GprRead and GprWrite are never both 1.
- Latency: op accepted at edge 0; OpsValid from cycle 3; with ResultValid in cycle 3, WB/Done in cycle 4, back to IDLE in cycle 5. Minimum op-to-op spacing is 5 cycles.
- Requests arriving outside IDLE wait; they are never lost or reordered.
- ResultValid outside EXEC is ignored.

Test Plan:
- Debug writes R1=0x1234, R2=0x0F0F; op Ra=1 Rb=2 Rd=3 WbEn=1, Result=0x1F43 in cycle 3 -> OpA=0x1234, OpB=0x0F0F, GprWrite at Rd=3 with 0x1F43 in cycle 4, Done one cycle; debug read R3 -> DbgRData=0x1F43.
- Op with Ra=0, Rd=0, WbEn=1 -> OpA=0, no GprWrite in WB, Done=1; debug read R0 -> 0.
- OpReq and DbgReq held together for 3 rounds -> grants alternate op, dbg, op, dbg, op, dbg.
- EXEC_TIMEOUT=4, ResultValid never asserted -> WB after 4 EXEC cycles, OpErr=1, Done=1, no GprWrite.
- Reset asserted during RD_B -> all outputs 0 immediately; no Done/DbgAck; next op after release starts cleanly with 5-cycle latency.
- Random ops and debug traffic against a reference model -> GprRead & GprWrite never both 1; register contents match the model.
